// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_send transmitter among NUM_REQ byte
// sources, keeping multi-byte messages contiguous by holding the grant.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 4096
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_READY,
  output logic [7:0]           TX_DATA,
  output logic                 TX_DATA_READY,
  input  logic                 TX_IDLE,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 BUSY,
  output logic                 ERR
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {ARB, WAIT_START, WAIT_DONE, HOLD} state_e;

  state_e             state_q, state_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_data_ready_q, tx_data_ready_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               lock_q, lock_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   sel_idx;
  logic [7:0]         sel_data;
  logic               sel_last;
  logic               accept;

  // Search upward from ptr+1 so the requester that last won is tried last.
  // NOTE: every signal written here gets a default first, so no path infers a latch.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == PTR_LAST) ? '0 : cand + 1'b1;
      if (!win_found && REQ_VALID[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // In HOLD the owner is ptr_q, which still points at the requester that won.
  always_comb begin
    sel_idx   = (state_q == HOLD) ? ptr_q : win_idx;
    REQ_READY = '0;
    if (RST && TX_IDLE) begin
      if (state_q == ARB && win_found) begin
        REQ_READY[win_idx] = 1'b1;
      end else if (state_q == HOLD) begin
        REQ_READY[ptr_q] = REQ_VALID[ptr_q];
      end
    end
    accept   = |(REQ_READY & REQ_VALID);
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) begin
        sel_data = REQ_DATA[8*i +: 8];
        sel_last = REQ_LAST[i];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    tx_data_d       = tx_data_q;
    tx_data_ready_d = 1'b0;
    grant_d         = grant_q;
    err_d           = 1'b0;
    lock_d          = lock_q;
    cnt_d           = cnt_q;
    ptr_d           = ptr_q;
    unique case (state_q)
      ARB, HOLD: begin
        if (accept) begin
          tx_data_d       = sel_data;
          lock_d          = ~sel_last;
          tx_data_ready_d = 1'b1;
          cnt_d           = '0;
          state_d         = WAIT_START;
          if (state_q == ARB) begin
            grant_d = NUM_REQ'(1) << win_idx;
            ptr_d   = win_idx;
          end
        end
      end
      WAIT_START: begin
        if (!TX_IDLE) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // uart_send never started: drop the byte and free the line.
          err_d   = 1'b1;
          grant_d = '0;
          lock_d  = 1'b0;
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (TX_IDLE) begin
          if (lock_q) begin
            state_d = HOLD;
          end else begin
            grant_d = '0;
            state_d = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
    busy_d = (state_d != ARB);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its _d and simulation matches hardware.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q         <= ARB;
      tx_data_q       <= 8'h00;
      tx_data_ready_q <= 1'b0;
      grant_q         <= '0;
      busy_q          <= 1'b0;
      err_q           <= 1'b0;
      lock_q          <= 1'b0;
      cnt_q           <= '0;
      ptr_q           <= PTR_LAST;
    end else begin
      state_q         <= state_d;
      tx_data_q       <= tx_data_d;
      tx_data_ready_q <= tx_data_ready_d;
      grant_q         <= grant_d;
      busy_q          <= busy_d;
      err_q           <= err_d;
      lock_q          <= lock_d;
      cnt_q           <= cnt_d;
      ptr_q           <= ptr_d;
    end
  end

  assign TX_DATA       = tx_data_q;
  assign TX_DATA_READY = tx_data_ready_q;
  assign GRANT         = grant_q;
  assign BUSY          = busy_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a uart_send model serialises bytes and
// the line order is compared against expectations queued with the stimulus.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NUM_REQ       = 4;
  localparam int START_TIMEOUT = 16;
  localparam int BIT_CYC       = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_data_ready;
  logic                 tx_idle;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic                 err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .START_TIMEOUT(START_TIMEOUT)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .REQ_VALID    (req_valid),
    .REQ_DATA     (req_data),
    .REQ_LAST     (req_last),
    .REQ_READY    (req_ready),
    .TX_DATA      (tx_data),
    .TX_DATA_READY(tx_data_ready),
    .TX_IDLE      (tx_idle),
    .GRANT        (grant),
    .BUSY         (busy),
    .ERR          (err)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
  } item_t;

  item_t              src_q [NUM_REQ][$];
  logic [7:0]         exp_q[$];
  logic [7:0]         rx_q[$];
  logic [NUM_REQ-1:0] rx_grant_q[$];
  bit                 line_bits [10];
  bit                 uart_en = 1'b1;
  int                 n_checks = 0;
  int                 n_pass = 0;
  int                 rdy_cycles [NUM_REQ];
  int                 multi_rdy = 0;
  int                 gated_rdy = 0;

  // uart_send model: drops IDLE as soon as it sees the start pulse.
  initial begin : uart_model
    logic [9:0]         frame;
    logic [NUM_REQ-1:0] cap_grant;
    tx_idle = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (uart_en && tx_data_ready) begin
        frame     = {1'b1, tx_data, 1'b0};
        cap_grant = grant;
        tx_idle   = 1'b0;
        for (int b = 0; b < 10; b++) begin
          line_bits[b] = frame[b];
          repeat (BIT_CYC) begin
            @(posedge clk); #1;
          end
        end
        tx_idle = 1'b1;
        rx_q.push_back(frame[8:1]);
        rx_grant_q.push_back(cap_grant);
      end
    end
  end

  // Requester driver: presents queue heads, pops what was accepted at the edge.
  initial begin : req_driver
    logic [NUM_REQ-1:0] acc_v;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk);
      acc_v = req_valid & req_ready;
      if ($countones(req_ready) > 1) multi_rdy++;
      if (req_ready != '0 && (!tx_idle || !rst)) gated_rdy++;
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cycles[i]++;
      @(posedge clk); #3;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc_v[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        if (src_q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = src_q[i][0].data;
          req_last[i]        = src_q[i][0].last;
        end else begin
          req_valid[i]       = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i]        = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    item_t it;
    it.data = d;
    it.last = l;
    src_q[r].push_back(it);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_rx(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      if (rx_q.size() > 0) ok = 1'b1;
      else tick();
    end
    if (rx_q.size() > 0) ok = 1'b1;
  endtask

  task automatic wait_grant(input logic [NUM_REQ-1:0] g, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      tick();
      if (grant === g) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    push(0, 8'hE1, 1'b1);
    exp_q.push_back(8'hE1);
    tick();
    tick();
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b want 0000", req_ready); else n_pass++;
    n_checks++;
    if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", tx_data); else n_pass++;
    n_checks++;
    if (tx_data_ready !== 1'b0) $display("FAIL rst_tx_data_ready: got %b want 0", tx_data_ready); else n_pass++;
    n_checks++;
    if (grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", grant); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
    rst = 1'b1;
    begin
      bit ok;
      logic [7:0] e;
      e = exp_q.pop_front();
      wait_rx(200, ok);
      n_checks++;
      if (!ok) $display("FAIL rst_first_byte: got nothing want %h", e);
      else if (rx_q[0] !== e) $display("FAIL rst_first_byte: got %h want %h", rx_q[0], e);
      else n_pass++;
      if (ok) begin
        void'(rx_q.pop_front());
        void'(rx_grant_q.pop_front());
      end
    end
    tick();
  endtask

  task automatic test_single();
    bit ok;
    logic [7:0] e;
    logic [9:0] got_v, exp_v;
    bit exp_frame [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    for (int i = 0; i < NUM_REQ; i++) rdy_cycles[i] = 0;
    push(2, 8'hAA, 1'b1);
    exp_q.push_back(8'hAA);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (tx_data_ready === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) $display("FAIL single_pulse: got no TX_DATA_READY want pulse");
    else if (tx_data !== 8'hAA) $display("FAIL single_pulse: got TX_DATA %h want aa", tx_data);
    else n_pass++;
    n_checks++;
    if (grant !== 4'b0100 || busy !== 1'b1) $display("FAIL single_grant: got grant %b busy %b want 0100 1", grant, busy);
    else n_pass++;
    tick();
    n_checks++;
    if (tx_data_ready !== 1'b0 || tx_data !== 8'hAA)
      $display("FAIL single_pulse_len: got ready %b data %h want 0 aa", tx_data_ready, tx_data);
    else n_pass++;
    e = exp_q.pop_front();
    wait_rx(200, ok);
    n_checks++;
    if (!ok) $display("FAIL single_byte: got nothing want %h", e);
    else if (rx_q[0] !== e) $display("FAIL single_byte: got %h want %h", rx_q[0], e);
    else n_pass++;
    for (int b = 0; b < 10; b++) begin
      got_v[b] = line_bits[b];
      exp_v[b] = exp_frame[b];
    end
    n_checks++;
    if (got_v !== exp_v) $display("FAIL single_frame: got %b want %b (bit0 first = lsb)", got_v, exp_v); else n_pass++;
    if (ok) begin
      void'(rx_q.pop_front());
      void'(rx_grant_q.pop_front());
    end
    tick();
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL single_release: got grant %b busy %b want 0000 0", grant, busy);
    else n_pass++;
    n_checks++;
    if (rdy_cycles[2] !== 1) $display("FAIL single_ready_len: got %0d cycles want 1", rdy_cycles[2]); else n_pass++;
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [7:0] e;
    logic [NUM_REQ-1:0] g, prev_g, exp_g;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        push(r, 8'h10 + 8'(r), 1'b1);
        exp_q.push_back(8'h10 + 8'(r));
      end
    end
    prev_g = '0;
    for (int k = 0; k < 2*NUM_REQ; k++) begin
      e     = exp_q.pop_front();
      exp_g = 4'(1) << (k % NUM_REQ);
      wait_rx(200, ok);
      n_checks++;
      if (!ok) begin
        $display("FAIL rr_byte%0d: got nothing want %h", k, e);
      end else begin
        logic [7:0] got;
        got = rx_q.pop_front();
        g   = rx_grant_q.pop_front();
        if (got !== e || g !== exp_g || g === prev_g)
          $display("FAIL rr_byte%0d: got %h grant %b want %h grant %b", k, got, g, e, exp_g);
        else n_pass++;
        prev_g = g;
      end
    end
  endtask

  task automatic test_lock_message();
    bit ok;
    int bad;
    logic [7:0] e;
    logic [NUM_REQ-1:0] exp_g [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
    push(1, 8'h4C, 1'b0);
    push(1, 8'h01, 1'b0);
    push(1, 8'h02, 1'b1);
    wait_grant(4'b0010, 20, ok);
    n_checks++;
    if (!ok) $display("FAIL lock_grant: got %b want 0010", grant); else n_pass++;
    push(0, 8'h0A, 1'b1);
    exp_q.push_back(8'h4C);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h0A);
    bad = 0;
    for (int c = 0; c < 600 && rx_q.size() < 3; c++) begin
      tick();
      if (rx_q.size() < 3 && grant !== 4'b0010) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL lock_grant_held: got %0d cycles off 0010 want 0", bad); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      wait_rx(200, ok);
      n_checks++;
      if (!ok) begin
        $display("FAIL lock_byte%0d: got nothing want %h", k, e);
      end else begin
        logic [7:0] got;
        logic [NUM_REQ-1:0] g;
        got = rx_q.pop_front();
        g   = rx_grant_q.pop_front();
        if (got !== e || g !== exp_g[k])
          $display("FAIL lock_byte%0d: got %h grant %b want %h grant %b", k, got, g, e, exp_g[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_lock_gap();
    bit ok;
    int bad;
    logic [7:0] e;
    logic [NUM_REQ-1:0] exp_g [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000};
    push(1, 8'hA5, 1'b0);
    wait_grant(4'b0010, 20, ok);
    n_checks++;
    if (!ok) $display("FAIL gap_grant: got %b want 0010", grant); else n_pass++;
    push(3, 8'h33, 1'b1);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hB6);
    exp_q.push_back(8'hC7);
    exp_q.push_back(8'h33);
    wait_rx(200, ok);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (req_ready[3] !== 1'b0 || busy !== 1'b1 || grant !== 4'b0010) bad++;
    end
    n_checks++;
    if (!ok || bad != 0) $display("FAIL gap_hold: got %0d bad cycles (byte seen %b) want 0 (1)", bad, ok); else n_pass++;
    push(1, 8'hB6, 1'b0);
    push(1, 8'hC7, 1'b1);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      wait_rx(200, ok);
      n_checks++;
      if (!ok) begin
        $display("FAIL gap_byte%0d: got nothing want %h", k, e);
      end else begin
        logic [7:0] got;
        logic [NUM_REQ-1:0] g;
        got = rx_q.pop_front();
        g   = rx_grant_q.pop_front();
        if (got !== e || g !== exp_g[k])
          $display("FAIL gap_byte%0d: got %h grant %b want %h grant %b", k, got, g, e, exp_g[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int c;
    logic [7:0] e;
    uart_en = 1'b0;
    push(2, 8'h55, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (tx_data_ready === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) $display("FAIL to_pulse: got no TX_DATA_READY want pulse"); else n_pass++;
    c = 0;
    while (c < 40 && err !== 1'b1) begin
      tick();
      c++;
    end
    n_checks++;
    if (c != START_TIMEOUT) $display("FAIL to_delay: got ERR after %0d cycles want %0d", c, START_TIMEOUT); else n_pass++;
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL to_release: got grant %b busy %b want 0000 0", grant, busy);
    else n_pass++;
    uart_en = 1'b1;
    push(3, 8'h66, 1'b1);
    exp_q.push_back(8'h66);
    tick();
    n_checks++;
    if (err !== 1'b0) $display("FAIL to_err_len: got %b want 0", err); else n_pass++;
    e = exp_q.pop_front();
    wait_rx(200, ok);
    n_checks++;
    if (!ok) begin
      $display("FAIL to_next: got nothing want %h", e);
    end else begin
      logic [7:0] got;
      logic [NUM_REQ-1:0] g;
      got = rx_q.pop_front();
      g   = rx_grant_q.pop_front();
      if (got !== e || g !== 4'b1000) $display("FAIL to_next: got %h grant %b want %h grant 1000", got, g, e);
      else n_pass++;
    end
    repeat (5) tick();
    n_checks++;
    if (rx_q.size() != 0) $display("FAIL to_no_retry: got %0d extra bytes want 0", rx_q.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [7:0] e;
    logic [NUM_REQ-1:0] exp_g [3] = '{4'b0010, 4'b0001, 4'b1000};
    push(1, 8'h5A, 1'b1);
    exp_q.push_back(8'h5A);
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      tick();
      if (busy === 1'b1 && tx_idle === 1'b0) ok = 1'b1;
    end
    repeat (5) tick();
    rst = 1'b0;
    push(0, 8'h01, 1'b1);
    push(3, 8'h03, 1'b1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h03);
    tick();
    n_checks++;
    if (!ok || tx_data !== 8'h00 || tx_data_ready !== 1'b0 || grant !== 4'b0000 ||
        busy !== 1'b0 || err !== 1'b0 || req_ready !== 4'b0000)
      $display("FAIL mid_reset_vals: got data %h rdy %b grant %b busy %b err %b ready %b (in flight %b) want 00 0 0000 0 0 0000 (1)",
               tx_data, tx_data_ready, grant, busy, err, req_ready, ok);
    else n_pass++;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      e = exp_q.pop_front();
      wait_rx(200, ok);
      n_checks++;
      if (!ok) begin
        $display("FAIL mid_byte%0d: got nothing want %h", k, e);
      end else begin
        logic [7:0] got;
        logic [NUM_REQ-1:0] g;
        got = rx_q.pop_front();
        g   = rx_grant_q.pop_front();
        if (got !== e || g !== exp_g[k])
          $display("FAIL mid_byte%0d: got %h grant %b want %h grant %b", k, got, g, e, exp_g[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_ready_rules();
    n_checks++;
    if (multi_rdy != 0) $display("FAIL ready_onehot: got %0d multi-hot cycles want 0", multi_rdy); else n_pass++;
    n_checks++;
    if (gated_rdy != 0) $display("FAIL ready_gated: got %0d cycles ready while busy/reset want 0", gated_rdy); else n_pass++;
  endtask

  initial begin : main
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) rdy_cycles[i] = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_lock_message();
    test_lock_gap();
    test_timeout();
    test_reset_mid();
    test_ready_rules();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares the single `uart_send` transmitter between several byte sources (debug/status, camera register dump, frame statistics). It accepts bytes over a valid/ready handshake, drives `DATA`/`DATA_READY` of `uart_send` and tracks its `IDLE` output so exactly one byte is in flight. Multi-byte messages are kept contiguous on the line by holding the grant until the requester marks the last byte.

## Interface
- `NUM_REQ`, 4: number of requesters, legal range 2..8.
- `START_TIMEOUT`, 4096: maximum CLK cycles to wait for `TX_IDLE` to fall after a `TX_DATA_READY` pulse.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset; one clock; reset is synchronous and active-low.
- `REQ_VALID`  in  NUM_REQ  per-requester byte valid.
- `REQ_DATA`  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- `REQ_LAST`  in  NUM_REQ  qualifies the byte as the last of a message; sampled with the byte.
- `REQ_READY`  out  NUM_REQ  byte accepted when `REQ_VALID[i] & REQ_READY[i]`; at most one bit high.
- `TX_DATA`  out  8  byte to `uart_send.DATA`.
- `TX_DATA_READY`  out  1  one-cycle start pulse to `uart_send.DATA_READY`.
- `TX_IDLE`  in  1  `uart_send.IDLE`.
- `GRANT`  out  NUM_REQ  one-hot owner of the transmitter; 0 when free.
- `BUSY`  out  1  high whenever state is not ARB.
- `ERR`  out  1  one-cycle pulse on start timeout.

## Operation
- States: ARB, WAIT_START, WAIT_DONE, HOLD.
- ARB: eligible when `TX_IDLE`=1 and any `REQ_VALID`. Winner is the first valid index searching upward from `ptr+1` mod NUM_REQ. `REQ_READY[winner]`=1 combinationally that cycle. On the accept edge:
  - latch `TX_DATA`;
  - set `GRANT`=onehot(winner) and `ptr`=winner;
  - set `lock`=~`REQ_LAST[winner]`;
  - set `TX_DATA_READY`=1;
  - go to WAIT_START.
- WAIT_START:
  - `TX_DATA_READY` is high only in the first cycle.
  - `TX_DATA` is held stable throughout.
  - Start counter increments each cycle. `TX_IDLE`=0 goes to WAIT_DONE.
  - Counter reaching START_TIMEOUT-1 with `TX_IDLE` still 1: pulse `ERR`, clear `GRANT` and `lock`, go to ARB. The byte is dropped and not retried.
- WAIT_DONE: on `TX_IDLE`=1, go to HOLD if `lock`, else go to ARB with `GRANT` cleared.
- HOLD: only the granted requester is served. `REQ_READY[g]`=`REQ_VALID[g]`. Accept behaves as in ARB without arbitration, and `ptr` is unchanged. HOLD waits indefinitely for `REQ_VALID[g]`. Other requesters stay blocked.
- `REQ_READY` is 0 in WAIT_START and WAIT_DONE, in ARB/HOLD while `TX_IDLE`=0, and while `RST`=0.
- Requesters must hold `REQ_VALID`, `REQ_DATA` and `REQ_LAST` stable until accepted.

## Timing
- Reset values (`RST`=0 at an edge):
  - state ARB;
  - `TX_DATA`=8'h00, `TX_DATA_READY`=0, `GRANT`=0, `BUSY`=0, `ERR`=0;
  - `lock`=0, start counter 0;
  - `ptr`=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-message or mid-byte: all state is discarded. No accept happens until `TX_IDLE`=1 is seen in ARB. A byte that `uart_send` is still shifting is not cut by this block.
- Accept in cycle N:
  - `TX_DATA_READY` high in cycle N+1 only;
  - `BUSY` and `GRANT` valid from N+1;
  - earliest next accept is the cycle after `TX_IDLE` returns high.
- Back-to-back bytes are therefore separated only by the `uart_send` stop bit plus 1 CLK.
- Simultaneous valid in ARB: the rotating pointer decides. A requester that just released is lowest priority.
- `REQ_LAST`=1 on a single byte: no lock; behaves as an independent transfer.
- `TX_IDLE` dropping in the same cycle as `TX_DATA_READY` is legal and goes to WAIT_DONE the next edge.

## Test plan
- After reset, only requester 2 valid with 8'hAA, LAST=1 -> `REQ_READY[2]` high 1 cycle, then `TX_DATA_READY` pulse with `TX_DATA`=8'hAA. The `uart_send` model shows TXD frame 0,0,1,0,1,0,1,0,1,1. `GRANT` returns to 0 when `IDLE` rises.
- All 4 requesters valid continuously, single-byte messages 8'h10..8'h13 -> line order 8'h10, 8'h11, 8'h12, 8'h13, 8'h10, with no requester served twice in a row.
- Requester 1 sends 3-byte message 8'h4C, 8'h01, 8'h02 (LAST on the third) while requester 0 is valid -> all three of requester 1's bytes go out contiguously, then requester 0. `GRANT`=4'b0010 throughout.
- Lock with a 50-cycle gap before requester 1's second byte, requester 3 valid -> arbiter stays in HOLD, `REQ_READY[3]`=0 for the whole gap.
- `TX_IDLE` tied high, START_TIMEOUT=16 -> `ERR` pulses exactly 16 cycles after `TX_DATA_READY`, `GRANT`=0, and the next requester is accepted afterwards.
- `RST`=0 asserted in WAIT_DONE with `TX_IDLE`=0 -> all outputs at reset values the next cycle. No accept until `TX_IDLE`=1; then requester 0 wins a 0/3 tie.
